// File: rtl/program_loader.sv
// Byte-stream program loader: assembles big-endian words from a valid/ready byte stream
// and writes them to consecutive instruction memory addresses starting at 0.
module program_loader #(
    parameter int unsigned DATA_LENGTH = 32,
    parameter int unsigned MEM_LENGHT  = 32,
    localparam int unsigned AW         = $clog2(MEM_LENGHT)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [AW:0]            num_words,
    input  logic                   abort,
    input  logic [7:0]             byte_in,
    input  logic                   byte_valid,
    output logic                   byte_ready,
    output logic                   wr_en,
    output logic [AW-1:0]          wr_addr,
    output logic [DATA_LENGTH-1:0] wr_data,
    output logic                   busy,
    output logic                   done,
    output logic [AW:0]            word_count
);

    localparam int unsigned BYTES = DATA_LENGTH / 8;
    localparam int unsigned BW    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [AW:0] MemW  = (AW + 1)'(MEM_LENGHT);

    typedef enum logic [1:0] {StIdle, StLoad, StWrite, StDone} state_e;

    state_e                 state_q, state_d;
    logic [BW-1:0]          byte_cnt_q, byte_cnt_d;
    logic [DATA_LENGTH-1:0] shift_q, shift_d;
    logic [AW:0]            target_q, target_d;
    logic [AW:0]            word_count_q, word_count_d;
    logic [AW-1:0]          wr_addr_q, wr_addr_d;
    logic [AW:0]            target_new;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            byte_cnt_q   <= '0;
            shift_q      <= '0;
            target_q     <= '0;
            word_count_q <= '0;
            wr_addr_q    <= '0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            shift_q      <= shift_d;
            target_q     <= target_d;
            word_count_q <= word_count_d;
            wr_addr_q    <= wr_addr_d;
        end
    end

    // Clamping the target keeps wr_addr inside the memory without any wrap logic.
    assign target_new = (num_words > MemW) ? MemW : num_words;

    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        shift_d      = shift_q;
        target_d     = target_q;
        word_count_d = word_count_q;
        wr_addr_d    = wr_addr_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    target_d     = target_new;
                    word_count_d = '0;
                    wr_addr_d    = '0;
                    byte_cnt_d   = '0;
                    state_d      = (target_new == '0) ? StDone : StLoad;
                end
            end
            StLoad: begin
                if (abort) begin
                    byte_cnt_d = '0;
                    state_d    = StIdle;
                end else if (byte_valid) begin
                    shift_d = (shift_q << 8) | DATA_LENGTH'(byte_in);
                    if (byte_cnt_q == BW'(BYTES - 1)) begin
                        byte_cnt_d = '0;
                        state_d    = StWrite;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end
            end
            StWrite: begin
                // The write strobe of an aborted WRITE still fires, but it is not counted.
                if (abort) begin
                    state_d = StIdle;
                end else begin
                    word_count_d = word_count_q + 1'b1;
                    if (word_count_q + 1'b1 == target_q) begin
                        state_d = StDone;
                    end else begin
                        wr_addr_d = wr_addr_q + 1'b1;
                        state_d   = StLoad;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        byte_ready = (state_q == StLoad);
        wr_en      = (state_q == StWrite);
        busy       = (state_q == StLoad) || (state_q == StWrite);
        done       = (state_q == StDone);
        wr_addr    = wr_addr_q;
        wr_data    = shift_q;
        word_count = word_count_q;
    end

endmodule

// File: tb/tb_program_loader.sv
// Randomized self-checking bench for program_loader: expected writes are built from the
// byte stream itself (word w = bytes 4w..4w+3, big-endian, at address w).
module tb_program_loader;

    localparam int unsigned DW = 32;
    localparam int unsigned MW = 32;
    localparam int unsigned AW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW:0]   num_words;
    logic          abort;
    logic [7:0]    byte_in;
    logic          byte_valid;
    logic          byte_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          busy;
    logic          done;
    logic [AW:0]   word_count;

    program_loader #(.DATA_LENGTH(DW), .MEM_LENGHT(MW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .num_words  (num_words),
        .abort      (abort),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic [7:0]    stim [0:255];
    logic [AW-1:0] obs_addr [$];
    logic [DW-1:0] obs_data [$];
    int            cyc = 0;
    int            last_hs_cyc = 0;
    int            hs_cnt = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (byte_valid && byte_ready) begin
            hs_cnt      <= hs_cnt + 1;
            last_hs_cyc <= cyc;
        end
    end

    always @(negedge clk) begin
        if (wr_en) begin
            obs_addr.push_back(wr_addr);
            obs_data.push_back(wr_data);
            check_eq("wr_latency", 64'(cyc), 64'(last_hs_cyc + 1));
        end
    end

    function automatic logic [DW-1:0] model_word(input int w);
        return {stim[4*w], stim[4*w+1], stim[4*w+2], stim[4*w+3]};
    endfunction

    task automatic fill_random();
        for (int i = 0; i < 256; i++) stim[i] = 8'($urandom);
    endtask

    task automatic pulse_start(input int n);
        obs_addr.delete();
        obs_data.delete();
        @(negedge clk);
        start     = 1'b1;
        num_words = (AW + 1)'(n);
        @(negedge clk);
        start = 1'b0;
    endtask

    // A byte offered at a negedge with byte_ready high is taken at the next posedge.
    task automatic feed(input int nbytes, input bit gaps);
        int idx = 0;
        int budget = 0;
        while (idx < nbytes && budget < 2000) begin
            @(negedge clk);
            budget++;
            byte_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            byte_in    = stim[idx];
            if (byte_valid && byte_ready) idx++;
        end
        @(negedge clk);
        byte_valid = 1'b0;
        if (idx != nbytes) check_eq("feed_timeout", 64'(idx), 64'(nbytes));
    endtask

    task automatic do_load(input int n, input bit gaps);
        int tgt = (n > int'(MW)) ? int'(MW) : n;
        int hs0;
        int waited = 0;
        pulse_start(n);
        hs0 = hs_cnt;
        feed(tgt * 4, gaps);
        while (!done && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check_eq("done", 64'(done), 64'(1));
        check_eq("busy_done", 64'(busy), 64'(0));
        check_eq("word_count", 64'(word_count), 64'(tgt));
        check_eq("n_writes", 64'(obs_addr.size()), 64'(tgt));
        check_eq("bytes_taken", 64'(hs_cnt - hs0), 64'(tgt * 4));
        for (int w = 0; w < obs_addr.size() && w < tgt; w++) begin
            check_eq($sformatf("addr[%0d]", w), 64'(obs_addr[w]), 64'(w));
            check_eq($sformatf("data[%0d]", w), 64'(obs_data[w]), 64'(model_word(w)));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_ready"}, 64'(byte_ready), 64'(0));
        check_eq({tag, "_wr_en"}, 64'(wr_en), 64'(0));
        check_eq({tag, "_busy"}, 64'(busy), 64'(0));
        check_eq({tag, "_done"}, 64'(done), 64'(0));
        check_eq({tag, "_addr"}, 64'(wr_addr), 64'(0));
        check_eq({tag, "_data"}, 64'(wr_data), 64'(0));
        check_eq({tag, "_count"}, 64'(word_count), 64'(0));
    endtask

    initial begin
        logic [7:0] dir [0:7];
        dir = '{8'h30, 8'h0C, 8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; byte_valid = 1'b0; byte_in = '0;
        num_words = '0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // Idle with a valid stream and no start: nothing is accepted or written.
        byte_valid = 1'b1;
        byte_in    = 8'hA5;
        repeat (4) begin
            @(negedge clk);
            check_eq("idle_ready", 64'(byte_ready), 64'(0));
        end
        byte_valid = 1'b0;
        check_eq("idle_writes", 64'(obs_addr.size()), 64'(0));
        check_eq("idle_done", 64'(done), 64'(0));

        for (int i = 0; i < 8; i++) stim[i] = dir[i];
        do_load(2, 1'b0);
        do_load(2, 1'b1);

        // Zero-length load finishes on the following cycle without writing.
        pulse_start(0);
        check_eq("zero_done", 64'(done), 64'(1));
        check_eq("zero_count", 64'(word_count), 64'(0));
        repeat (3) @(negedge clk);
        check_eq("zero_writes", 64'(obs_addr.size()), 64'(0));

        fill_random();
        do_load(40, 1'b0);
        byte_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_eq("full_ready", 64'(byte_ready), 64'(0));
        end
        byte_valid = 1'b0;

        for (int r = 0; r < 4; r++) begin
            fill_random();
            do_load(int'($urandom_range(1, 6)), 1'($urandom_range(0, 1)));
        end

        // Abort two bytes into the second word.
        fill_random();
        pulse_start(3);
        feed(6, 1'b0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_eq("abort_busy", 64'(busy), 64'(0));
        check_eq("abort_done", 64'(done), 64'(0));
        check_eq("abort_count", 64'(word_count), 64'(1));
        repeat (3) @(negedge clk);
        check_eq("abort_writes", 64'(obs_addr.size()), 64'(1));
        fill_random();
        do_load(1, 1'b0);

        // Abort landing on the WRITE cycle: the write happens but is not counted.
        fill_random();
        pulse_start(2);
        feed(4, 1'b0);
        check_eq("abw_wr_en", 64'(wr_en), 64'(1));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_eq("abw_busy", 64'(busy), 64'(0));
        check_eq("abw_done", 64'(done), 64'(0));
        check_eq("abw_count", 64'(word_count), 64'(0));
        check_eq("abw_writes", 64'(obs_addr.size()), 64'(1));
        if (obs_data.size() > 0) check_eq("abw_data", 64'(obs_data[0]), 64'(model_word(0)));

        // Asynchronous reset in the middle of a load.
        fill_random();
        pulse_start(2);
        feed(5, 1'b1);
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        fill_random();
        do_load(2, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
